// File: rtl/pattern_pkg.sv
// Shared constants and button FSM encoding for the pattern-detector front end.
package pattern_pkg;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned PRESS_CNT_W         = 8;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_state_t;

endpackage

// File: rtl/debounce_sync.sv
// Single-bit synchroniser chain followed by a persistence-count debouncer.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // A new level is accepted only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (sync_bit != level) begin
      if (cnt_q == CNT_LAST) begin
        level <= sync_bit;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/pattern_input_conditioner.sv
// Turns the raw button/switch pins into a clean trig strobe plus captured data bit.
module pattern_input_conditioner
  import pattern_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_in,
  input  logic                   sw_in,
  output logic                   data,
  output logic                   trig,
  output logic                   btn_level,
  output logic [PRESS_CNT_W-1:0] press_cnt
);

  logic                   btn_db;
  logic                   sw_db;
  btn_state_t             state_q, state_d;
  logic                   trig_d;
  logic                   data_d;
  logic [PRESS_CNT_W-1:0] press_cnt_d;

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_db (
    .clk  (clk),
    .reset(reset),
    .din  (btn_in),
    .level(btn_db)
  );

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_db (
    .clk  (clk),
    .reset(reset),
    .din  (sw_in),
    .level(sw_db)
  );

  // The debounced level is already a flop output.
  assign btn_level = btn_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BTN_RELEASED;
      trig      <= 1'b0;
      data      <= 1'b0;
      press_cnt <= '0;
    end else begin
      state_q   <= state_d;
      trig      <= trig_d;
      data      <= data_d;
      press_cnt <= press_cnt_d;
    end
  end

  // Data samples the switch level held before the accepting edge.
  always_comb begin
    state_d     = state_q;
    trig_d      = 1'b0;
    data_d      = data;
    press_cnt_d = press_cnt;
    case (state_q)
      BTN_RELEASED: begin
        if (btn_db) begin
          state_d     = BTN_PRESSED;
          trig_d      = 1'b1;
          data_d      = sw_db;
          press_cnt_d = press_cnt + PRESS_CNT_W'(1);
        end
      end
      BTN_PRESSED: begin
        if (!btn_db) begin
          state_d = BTN_RELEASED;
        end
      end
      default: state_d = BTN_RELEASED;
    endcase
  end

endmodule

// File: tb/tb_pattern_input_conditioner.sv
// Directed bench for pattern_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_pattern_input_conditioner;

  localparam int unsigned SYNC     = 2;
  localparam int unsigned DEB      = 4;
  localparam int unsigned TRIG_LAT = SYNC + DEB + 1;  // edges, sampling edge counted as 1
  localparam int unsigned LVL_LAT  = SYNC + DEB;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       sw_in;
  logic       data;
  logic       trig;
  logic       btn_level;
  logic [7:0] press_cnt;

  int n_checks    = 0;
  int n_fail      = 0;
  int trig_total  = 0;
  int double_trig = 0;
  int lvl_seen    = 0;
  logic trig_prev = 1'b0;

  typedef struct {
    logic sw;
    logic exp_data;
    int   exp_cnt;
  } feed_vec_t;

  feed_vec_t vecs[5];

  pattern_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .sw_in    (sw_in),
    .data     (data),
    .trig     (trig),
    .btn_level(btn_level),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock edge, then settle; tracks strobe count and back-to-back strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (trig) begin
      trig_total++;
      if (trig_prev) double_trig++;
    end
    if (btn_level) lvl_seen++;
    trig_prev = trig;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic press_release(input logic sw, output int n, output int d, output int c);
    int t0;
    d = -1;
    c = -1;
    sw_in = sw;
    repeat (10) tick();
    t0 = trig_total;
    btn_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (trig) begin
        d = int'(data);
        c = int'(press_cnt);
      end
    end
    btn_in = 1'b0;
    repeat (10) tick();
    n = trig_total - t0;
  endtask

  initial begin
    int n, d, c, t0;

    vecs[0] = '{sw: 1'b1, exp_data: 1'b1, exp_cnt: 1};
    vecs[1] = '{sw: 1'b1, exp_data: 1'b1, exp_cnt: 2};
    vecs[2] = '{sw: 1'b0, exp_data: 1'b0, exp_cnt: 3};
    vecs[3] = '{sw: 1'b1, exp_data: 1'b1, exp_cnt: 4};
    vecs[4] = '{sw: 1'b0, exp_data: 1'b0, exp_cnt: 5};

    reset  = 1'b1;
    btn_in = 1'b0;
    sw_in  = 1'b0;
    #2;
    check("reset_data", int'(data), 0);
    check("reset_trig", int'(trig), 0);
    check("reset_btn_level", int'(btn_level), 0);
    check("reset_press_cnt", int'(press_cnt), 0);
    do_reset();

    // Clean press with exact latency checks
    sw_in = 1'b1;
    repeat (10) tick();
    t0 = trig_total;
    btn_in = 1'b1;
    repeat (LVL_LAT - 1) tick();
    check("clean_level_early", int'(btn_level), 0);
    tick();
    check("clean_level_on_time", int'(btn_level), 1);
    check("clean_trig_early", int'(trig), 0);
    tick();
    check("clean_trig_on_time", int'(trig), 1);
    check("clean_data", int'(data), 1);
    check("clean_press_cnt", int'(press_cnt), 1);
    repeat (20 - TRIG_LAT) tick();
    check("clean_single_trig", trig_total - t0, 1);
    t0 = trig_total;
    btn_in = 1'b0;
    repeat (LVL_LAT - 1) tick();
    check("release_level_early", int'(btn_level), 1);
    tick();
    check("release_level_on_time", int'(btn_level), 0);
    repeat (10) tick();
    check("release_no_trig", trig_total - t0, 0);

    // Bounce rejection
    do_reset();
    t0 = trig_total;
    lvl_seen = 0;
    foreach (vecs[i]) begin end
    btn_in = 1'b1; tick();
    btn_in = 1'b0; tick();
    btn_in = 1'b1; tick();
    tick();
    btn_in = 1'b0;
    repeat (15) tick();
    check("bounce_no_trig", trig_total - t0, 0);
    check("bounce_level_never_high", lvl_seen, 0);
    check("bounce_press_cnt", int'(press_cnt), 0);

    // Pattern feed from vector table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press_release(vecs[i].sw, n, d, c);
      check($sformatf("feed%0d_trig_count", i), n, 1);
      check($sformatf("feed%0d_data", i), d, int'(vecs[i].exp_data));
      check($sformatf("feed%0d_press_cnt", i), c, vecs[i].exp_cnt);
    end
    check("feed_final_press_cnt", int'(press_cnt), 5);

    // Switch activity with no press
    t0 = trig_total;
    sw_in = 1'b1;
    repeat (10) tick();
    check("idle_sw_high_data", int'(data), 0);
    sw_in = 1'b0;
    repeat (10) tick();
    check("idle_sw_low_data", int'(data), 0);
    check("idle_no_trig", trig_total - t0, 0);
    check("idle_press_cnt", int'(press_cnt), 5);

    // Reset during debounce
    btn_in = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("midrst_data", int'(data), 0);
    check("midrst_trig", int'(trig), 0);
    check("midrst_btn_level", int'(btn_level), 0);
    check("midrst_press_cnt", int'(press_cnt), 0);
    tick();
    reset = 1'b0;
    t0 = trig_total;
    repeat (TRIG_LAT - 1) tick();
    check("midrst_trig_early", trig_total - t0, 0);
    tick();
    check("midrst_trig_on_time", int'(trig), 1);
    check("midrst_press_cnt_after", int'(press_cnt), 1);
    btn_in = 1'b0;
    repeat (10) tick();

    // Press counter wrap
    do_reset();
    t0 = trig_total;
    for (int i = 0; i < 256; i++) begin
      btn_in = 1'b1;
      repeat (8) tick();
      btn_in = 1'b0;
      repeat (8) tick();
      if (i == 254) check("wrap_cnt_255", int'(press_cnt), 255);
    end
    check("wrap_trig_total", trig_total - t0, 256);
    check("wrap_press_cnt", int'(press_cnt), 0);

    check("no_back_to_back_trig", double_trig, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
